// File: rtl/rs_dec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rs_dec_pkg : shared constants for the RS(32,28) decoder control slice
// Revision   : 1.0
// ---------------------------------------------------------------------------
package rs_dec_pkg;

   localparam int RS_N    = 32;
   localparam int RS_NSYM = 4;

   localparam logic [3:0] S_IDLE         = 4'd0;
   localparam logic [3:0] S_COLLECT      = 4'd1;
   localparam logic [3:0] S_SYND_WAIT    = 4'd2;
   localparam logic [3:0] S_EUCLID_START = 4'd3;
   localparam logic [3:0] S_EUCLID_WAIT  = 4'd4;
   localparam logic [3:0] S_CHIEN        = 4'd5;
   localparam logic [3:0] S_CHECK        = 4'd6;
   localparam logic [3:0] S_CORR         = 4'd7;
   localparam logic [3:0] S_DONE         = 4'd8;

   localparam logic [1:0] ST_CLEAN   = 2'd0;
   localparam logic [1:0] ST_CORR    = 2'd1;
   localparam logic [1:0] ST_UNCORR  = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rs_dec_hit_log.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rs_dec_hit_log : two Chien root position slots and a saturating hit count
// Revision       : 1.0
// ---------------------------------------------------------------------------
module rs_dec_hit_log (
   input  logic       i_clk,
   input  logic       i_resb,
   input  logic       i_clr,
   input  logic       i_cap,
   input  logic [4:0] i_pos,
   output logic [1:0] o_cnt,
   output logic [4:0] o_slot0,
   output logic [4:0] o_slot1
);

   logic [1:0] r_cnt;
   logic [4:0] r_slot0;
   logic [4:0] r_slot1;

   // Only the first two roots are kept; the count keeps going to 3 so a
   // third root is still visible as a locator/root mismatch.
   always_ff @(posedge i_clk or negedge i_resb) begin
      if (!i_resb) begin
         r_cnt   <= 2'd0;
         r_slot0 <= 5'd0;
         r_slot1 <= 5'd0;
      end else if (i_clr) begin
         r_cnt   <= 2'd0;
         r_slot0 <= 5'd0;
         r_slot1 <= 5'd0;
      end else if (i_cap) begin
         if (r_cnt == 2'd0) r_slot0 <= i_pos;
         if (r_cnt == 2'd1) r_slot1 <= i_pos;
         if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
      end
   end

   assign o_cnt   = r_cnt;
   assign o_slot0 = r_slot0;
   assign o_slot1 = r_slot1;

endmodule
`default_nettype wire

// File: rtl/rs_dec_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rs_dec_frame_ctrl : frame sequencer for the RS(32,28) decoder datapath
// Revision          : 1.0
// ---------------------------------------------------------------------------
module rs_dec_frame_ctrl
   import rs_dec_pkg::*;
#(
   parameter int N       = RS_N,
   parameter int TIMEOUT = 64
) (
   input  logic       i_clk,
   input  logic       i_resb,
   input  logic       i_frame_start,
   input  logic       i_sym_valid,
   output logic       o_synd_clr,
   output logic       o_synd_en,
   input  logic       i_synd_zero,
   output logic       o_synd_sync,
   input  logic       i_euclid_ready,
   input  logic [1:0] i_deg_lambda,
   output logic       o_chien_en,
   output logic [4:0] o_chien_pos,
   input  logic       i_chien_hit,
   output logic       o_corr_we,
   output logic [4:0] o_corr_pos,
   output logic       o_frame_done,
   output logic [1:0] o_status,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int                  c_SYM_W     = $clog2(N);
   localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 2);
   localparam logic [c_SYM_W-1:0]  c_SYM_LAST  = c_SYM_W'(N - 1);
   localparam logic [4:0]          c_POS_LAST  = 5'(N - 1);
   localparam logic [c_WAIT_W-1:0] c_GUARD     = c_WAIT_W'(2);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT + 1);

   logic [3:0]          r_state;
   logic [3:0]          w_state_nxt;
   logic [1:0]          r_status_pend;
   logic [1:0]          w_status_nxt;
   logic [c_SYM_W-1:0]  r_sym_cnt;
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic [4:0]          r_chien_pos;
   logic [4:0]          r_corr_pos;
   logic [1:0]          r_deg;
   logic [1:0]          r_status;
   logic                r_corr_idx;
   logic                r_synd_clr;
   logic                r_synd_sync;
   logic                r_chien_en;
   logic                r_corr_we;
   logic                r_frame_done;
   logic                r_overrun;
   logic                r_busy;

   logic [1:0]          w_hit_cnt;
   logic [4:0]          w_slot0;
   logic [4:0]          w_slot1;
   logic                w_start;
   logic                w_last_sym;
   logic                w_ready_ok;
   logic                w_deg_ok;
   logic                w_hit_cap;

   assign w_start    = i_frame_start && (r_state == S_IDLE);
   assign w_last_sym = (r_state == S_COLLECT) && i_sym_valid && (r_sym_cnt == c_SYM_LAST);
   assign w_ready_ok = (r_wait_cnt >= c_GUARD) && i_euclid_ready;
   assign w_deg_ok   = ((r_deg == 2'd1) || (r_deg == 2'd2)) && (w_hit_cnt == r_deg);
   assign w_hit_cap  = (r_state == S_CHIEN) && i_chien_hit;

   rs_dec_hit_log u_hit_log (
      .i_clk   (i_clk),
      .i_resb  (i_resb),
      .i_clr   (w_start),
      .i_cap   (w_hit_cap),
      .i_pos   (r_chien_pos),
      .o_cnt   (w_hit_cnt),
      .o_slot0 (w_slot0),
      .o_slot1 (w_slot1)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status_pend;
      case (r_state)
         S_IDLE:         if (w_start) w_state_nxt = S_COLLECT;
         S_COLLECT:      if (w_last_sym) w_state_nxt = S_SYND_WAIT;
         S_SYND_WAIT: begin
            if (i_synd_zero) begin
               w_state_nxt  = S_DONE;
               w_status_nxt = ST_CLEAN;
            end else begin
               w_state_nxt  = S_EUCLID_START;
            end
         end
         S_EUCLID_START: w_state_nxt = S_EUCLID_WAIT;
         S_EUCLID_WAIT: begin
            // A result on the last allowed cycle still wins over the timeout.
            if (w_ready_ok) begin
               w_state_nxt  = S_CHIEN;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt  = S_DONE;
               w_status_nxt = ST_TIMEOUT;
            end
         end
         S_CHIEN:        if (r_chien_pos == c_POS_LAST) w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (w_deg_ok) begin
               w_state_nxt  = S_CORR;
               w_status_nxt = ST_CORR;
            end else begin
               w_state_nxt  = S_DONE;
               w_status_nxt = ST_UNCORR;
            end
         end
         S_CORR: begin
            if (!r_corr_idx && (w_hit_cnt == 2'd2)) w_state_nxt = S_CORR;
            else                                    w_state_nxt = S_DONE;
         end
         S_DONE:         w_state_nxt = S_IDLE;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resb) begin
      if (!i_resb) begin
         r_state       <= S_IDLE;
         r_status_pend <= ST_CLEAN;
         r_status      <= ST_CLEAN;
         r_sym_cnt     <= '0;
         r_wait_cnt    <= '0;
         r_chien_pos   <= 5'd0;
         r_corr_pos    <= 5'd0;
         r_corr_idx    <= 1'b0;
         r_deg         <= 2'd0;
         r_synd_clr    <= 1'b0;
         r_synd_sync   <= 1'b0;
         r_chien_en    <= 1'b0;
         r_corr_we     <= 1'b0;
         r_frame_done  <= 1'b0;
         r_overrun     <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_status_pend <= w_status_nxt;
         r_busy        <= (w_state_nxt != S_IDLE);
         r_synd_clr    <= w_start;
         r_synd_sync   <= (w_state_nxt == S_EUCLID_START);
         r_chien_en    <= (w_state_nxt == S_CHIEN);
         r_corr_we     <= (w_state_nxt == S_CORR);
         r_frame_done  <= (w_state_nxt == S_DONE);
         r_overrun     <= i_frame_start && (r_state != S_IDLE);

         // Status only changes together with the done pulse.
         if (w_state_nxt == S_DONE) r_status <= w_status_nxt;

         if (w_start)
            r_sym_cnt <= '0;
         else if ((r_state == S_COLLECT) && i_sym_valid)
            r_sym_cnt <= r_sym_cnt + c_SYM_W'(1);

         if (r_state == S_EUCLID_WAIT) r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
         else                          r_wait_cnt <= '0;

         if ((r_state == S_EUCLID_WAIT) && w_ready_ok) r_deg <= i_deg_lambda;

         if (r_state == S_CHIEN) r_chien_pos <= r_chien_pos + 5'd1;
         else                    r_chien_pos <= 5'd0;

         if (r_state == S_CHECK) begin
            r_corr_idx <= 1'b0;
            r_corr_pos <= w_slot0;
         end else if ((r_state == S_CORR) && (w_state_nxt == S_CORR)) begin
            r_corr_idx <= 1'b1;
            r_corr_pos <= w_slot1;
         end
      end
   end

   assign o_synd_en    = (r_state == S_COLLECT) && i_sym_valid;
   assign o_synd_clr   = r_synd_clr;
   assign o_synd_sync  = r_synd_sync;
   assign o_chien_en   = r_chien_en;
   assign o_chien_pos  = r_chien_pos;
   assign o_corr_we    = r_corr_we;
   assign o_corr_pos   = r_corr_pos;
   assign o_frame_done = r_frame_done;
   assign o_status     = r_status;
   assign o_overrun    = r_overrun;
   assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rs_dec_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rs_dec_frame_ctrl : self-checking bench for rs_dec_frame_ctrl
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_rs_dec_frame_ctrl;

   localparam int c_TIMEOUT = 64;

   typedef struct {
      logic [1:0]  deg;
      bit          sz;
      int          rdy;     // ready rises at t+rdy; 0 = never, 3 = stuck high
      logic [31:0] mask;    // Chien root positions
      bit          gap;     // symbol with start, plus a gap mid-frame
      int          ovr;     // 1 = start during CHIEN, 2 = start in DONE
      int          e_status;
      int          e_done;  // done cycle relative to t
      int          e_nwr;
      int          e_p0;
      int          e_p1;
   } vec_t;

   typedef struct { int pos; int cyc; } wr_t;
   typedef struct { int status; int cyc; } dn_t;

   logic       i_clk = 1'b0;
   logic       i_resb = 1'b0;
   logic       i_frame_start = 1'b0;
   logic       i_sym_valid = 1'b0;
   logic       i_synd_zero = 1'b0;
   logic       i_euclid_ready = 1'b1;
   logic [1:0] i_deg_lambda = 2'd0;
   logic       i_chien_hit = 1'b0;
   logic       o_synd_clr, o_synd_en, o_synd_sync, o_chien_en, o_corr_we;
   logic       o_frame_done, o_overrun, o_busy;
   logic [4:0] o_chien_pos, o_corr_pos;
   logic [1:0] o_status;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   int  n_sync   = 0;
   int  n_clr    = 0;
   int  n_ovr    = 0;
   wr_t wr_q[$];
   dn_t done_q[$];
   wr_t m_wr;
   dn_t m_dn;
   vec_t vecs[12];

   rs_dec_frame_ctrl #(.N(32), .TIMEOUT(c_TIMEOUT)) dut (
      .i_clk          (i_clk),
      .i_resb         (i_resb),
      .i_frame_start  (i_frame_start),
      .i_sym_valid    (i_sym_valid),
      .o_synd_clr     (o_synd_clr),
      .o_synd_en      (o_synd_en),
      .i_synd_zero    (i_synd_zero),
      .o_synd_sync    (o_synd_sync),
      .i_euclid_ready (i_euclid_ready),
      .i_deg_lambda   (i_deg_lambda),
      .o_chien_en     (o_chien_en),
      .o_chien_pos    (o_chien_pos),
      .i_chien_hit    (i_chien_hit),
      .o_corr_we      (o_corr_we),
      .o_corr_pos     (o_corr_pos),
      .o_frame_done   (o_frame_done),
      .o_status       (o_status),
      .o_overrun      (o_overrun),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({o_synd_clr, o_synd_en, o_synd_sync, o_chien_en, o_chien_pos,
                   o_corr_we, o_corr_pos, o_frame_done, o_status, o_overrun, o_busy});
   endfunction

   // Scoreboard side: pops expectations as the DUT produces writes and done pulses.
   always @(negedge i_clk) begin
      if (o_synd_sync) n_sync++;
      if (o_synd_clr)  n_clr++;
      if (o_overrun)   n_ovr++;
      if (o_corr_we) begin
         if (wr_q.size() == 0) check("corr_we_unexpected", 1, 0);
         else begin
            m_wr = wr_q.pop_front();
            check("corr_pos", int'(o_corr_pos), m_wr.pos);
            check("corr_cycle", cyc, m_wr.cyc);
         end
      end
      if (o_frame_done) begin
         if (done_q.size() == 0) check("done_unexpected", 1, 0);
         else begin
            m_dn = done_q.pop_front();
            check("done_status", int'(o_status), m_dn.status);
            check("done_cycle", cyc, m_dn.cyc);
         end
      end
   end

   task automatic run_frame(input vec_t v, input int idx);
      int t, r, rel, s0, c0, o0;
      t = 0;
      s0 = n_sync; c0 = n_clr; o0 = n_ovr;
      i_deg_lambda = v.deg; i_synd_zero = v.sz; i_euclid_ready = 1'b1; i_chien_hit = 1'b0;
      @(negedge i_clk);
      i_frame_start = 1'b1;
      i_sym_valid   = v.gap;
      #1 check($sformatf("v%0d_synd_en_idle", idx), int'(o_synd_en), 0);
      @(negedge i_clk);
      i_frame_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (v.gap && k == 10) begin
            i_sym_valid = 1'b0;
            @(negedge i_clk);
         end
         i_sym_valid = 1'b1;
         if (k == 31) t = cyc;
         if (k == 5) #1 check($sformatf("v%0d_synd_en", idx), int'(o_synd_en), 1);
         @(negedge i_clk);
      end
      i_sym_valid = 1'b0;
      r = t + ((v.rdy > 5) ? v.rdy : 5);
      done_q.push_back('{v.e_status, t + v.e_done});
      for (int i = 0; i < v.e_nwr; i++)
         wr_q.push_back('{(i == 0) ? v.e_p0 : v.e_p1, r + 34 + i});
      while (cyc <= t + v.e_done + 1) begin
         rel = cyc - t;
         i_euclid_ready = (rel <= 2) || (v.rdy != 0 && rel >= v.rdy);
         i_chien_hit    = o_chien_en && v.mask[o_chien_pos];
         i_frame_start  = (v.ovr == 1 && o_chien_en && o_chien_pos == 5'd10) ||
                          (v.ovr == 2 && rel == 2);
         @(negedge i_clk);
      end
      i_frame_start = 1'b0; i_chien_hit = 1'b0; i_euclid_ready = 1'b1;
      check($sformatf("v%0d_done_missing", idx), done_q.size(), 0);
      check($sformatf("v%0d_writes_missing", idx), wr_q.size(), 0);
      done_q.delete();
      wr_q.delete();
      check($sformatf("v%0d_busy_after", idx), int'(o_busy), 0);
      check($sformatf("v%0d_status_hold", idx), int'(o_status), v.e_status);
      check($sformatf("v%0d_sync_count", idx), n_sync - s0, v.sz ? 0 : 1);
      check($sformatf("v%0d_clr_count", idx), n_clr - c0, 1);
      check($sformatf("v%0d_overrun_count", idx), n_ovr - o0, (v.ovr != 0) ? 1 : 0);
   endtask

   initial begin
      //          deg   sz    rdy mask                       gap   ovr st done nwr p0 p1
      vecs[0]  = '{2'd0, 1'b1, 0,  32'h0,                     1'b0, 2,  0, 2,  0, 0, 0};
      vecs[1]  = '{2'd1, 1'b0, 8,  32'h1 << 17,               1'b0, 0,  1, 43, 1, 17, 0};
      vecs[2]  = '{2'd2, 1'b0, 8,  (32'h1 << 3) | (32'h1 << 30), 1'b0, 1, 1, 44, 2, 3, 30};
      vecs[3]  = '{2'd2, 1'b0, 6,  32'h1 << 5,                1'b0, 0,  2, 40, 0, 0, 0};
      vecs[4]  = '{2'd2, 1'b0, 5,  32'h0000_000E,             1'b0, 0,  2, 39, 0, 0, 0};
      vecs[5]  = '{2'd1, 1'b0, 0,  32'h1 << 4,                1'b0, 0,  3, 69, 0, 0, 0};
      vecs[6]  = '{2'd1, 1'b0, 3,  32'h1,                     1'b0, 0,  1, 40, 1, 0, 0};
      vecs[7]  = '{2'd3, 1'b0, 7,  32'h0000_0380,             1'b0, 0,  2, 41, 0, 0, 0};
      vecs[8]  = '{2'd1, 1'b0, 10, 32'h8000_0000,             1'b1, 0,  1, 45, 1, 31, 0};
      vecs[9]  = '{2'd0, 1'b0, 5,  32'h0,                     1'b0, 0,  2, 39, 0, 0, 0};
      vecs[10] = '{2'd1, 1'b0, 5,  32'h0000_0003,             1'b0, 0,  2, 39, 0, 0, 0};
      vecs[11] = '{2'd2, 1'b0, 9,  32'h8000_0001,             1'b0, 0,  1, 45, 2, 0, 31};

      repeat (3) @(negedge i_clk);
      check("reset_outputs", all_outs(), 0);
      i_resb = 1'b1;
      repeat (2) @(negedge i_clk);
      check("idle_outputs", all_outs(), 0);

      for (int i = 0; i < 12; i++) run_frame(vecs[i], i);

      // Reset in the middle of COLLECT: no done pulse, back to idle.
      @(negedge i_clk);
      i_frame_start = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
      repeat (15) begin
         i_sym_valid = 1'b1;
         @(negedge i_clk);
      end
      check("midframe_busy", int'(o_busy), 1);
      i_resb = 1'b0;
      #1 check("midreset_outputs", all_outs(), 0);
      i_sym_valid = 1'b0;
      repeat (2) @(negedge i_clk);
      i_resb = 1'b1;
      repeat (40) @(negedge i_clk);
      check("midreset_idle", int'(o_busy), 0);

      run_frame(vecs[1], 12);
      run_frame(vecs[0], 13);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
